// File: rtl/ppbuf_read_ctrl_if.sv
// Read-side bus of the ping-pong interleaver buffer: the shared RAM read
// port of banks A/B plus the bit stream toward the modulator mapper.
//
// Handshake: a beat transfers on a rising clk edge where valid_out && ready_in
// are both high; once valid_out is high it stays high and q_out stays stable
// until that transfer happens.
interface ppbuf_read_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic              rden_A;
  logic              rden_B;
  logic [ADDR_W-1:0] rdaddress;
  logic              q_A;
  logic              q_B;
  logic              valid_out;
  logic              ready_in;
  logic              q_out;

  // controller side
  modport master (
    output rden_A, rden_B, rdaddress, valid_out, q_out,
    input  q_A, q_B, ready_in
  );

  // RAM/consumer side
  modport slave (
    input  rden_A, rden_B, rdaddress, valid_out, q_out,
    output q_A, q_B, ready_in
  );
endinterface

// File: rtl/ppbuf_read_ctrl.sv
// Read controller for the ping-pong interleaver buffer. Drains a full bank in
// block-interleaved order (row-major walk of a column-written matrix), streams
// the bits downstream and releases the bank to the writer after its last read.
module ppbuf_read_ctrl #(
  parameter int NCBPS      = 192,
  parameter int D          = 16,
  parameter int ADDR_W     = 8,
  parameter int INTERLEAVE = 1
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              wr_done_A,
  input  logic              wr_done_B,
  output logic              rd_done_A,
  output logic              rd_done_B,
  output logic              err_ovf,
  output logic [1:0]        state_dbg,
  ppbuf_read_ctrl_if.master bus
);

  localparam int ROWS = NCBPS / D;
  localparam int RW   = (D > 1) ? $clog2(D) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_READ = 2'd2;

  logic [1:0]        state;
  logic              full_A;
  logic              full_B;
  logic              rd_bank;     // 0 = A, 1 = B
  logic [ADDR_W-1:0] k;           // read index within the block
  logic [ADDR_W-1:0] addr;        // RAM address for index k
  logic [ADDR_W-1:0] col;         // current column (k / D)
  logic [RW-1:0]     row;         // current row (k mod D)
  logic              valid_r;
  logic              q_sel;

  logic adv;
  logic last;
  logic clr_A;
  logic clr_B;
  logic full_sel;
  logic other_full;

  // A read issues whenever the output register is empty or being emptied.
  assign adv        = (state == S_READ) && (!valid_r || bus.ready_in);
  assign last       = adv && (k == ADDR_W'(NCBPS - 1));
  assign clr_A      = last && !rd_bank;
  assign clr_B      = last &&  rd_bank;
  assign full_sel   = rd_bank ? full_B : full_A;
  // The bank after the current one, counting a wr_done landing this cycle.
  assign other_full = rd_bank ? (full_A || wr_done_A) : (full_B || wr_done_B);

  assign bus.rden_A    = adv && !rd_bank;
  assign bus.rden_B    = adv &&  rd_bank;
  assign bus.rdaddress = addr;
  assign bus.valid_out = valid_r;
  // Gated by valid so q_out is 0 out of reset regardless of stale RAM data.
  assign bus.q_out     = valid_r && (q_sel ? bus.q_B : bus.q_A);

  assign rd_done_A = clr_A;
  assign rd_done_B = clr_B;
  assign state_dbg = state;

  // Bank full flags: a fresh wr_done wins over the release of the same bank.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      full_A <= 1'b0;
      full_B <= 1'b0;
    end else begin
      if (wr_done_A)  full_A <= 1'b1;
      else if (clr_A) full_A <= 1'b0;
      if (wr_done_B)  full_B <= 1'b1;
      else if (clr_B) full_B <= 1'b0;
    end
  end

  // Sticky overflow: writer signalled a bank that is still unread.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      err_ovf <= 1'b0;
    end else if ((wr_done_A && full_A && !clr_A) ||
                 (wr_done_B && full_B && !clr_B)) begin
      err_ovf <= 1'b1;
    end
  end

  // Sequencer: wait for the current bank, drain it, hop to the other bank.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= S_IDLE;
      rd_bank <= 1'b0;
    end else begin
      case (state)
        S_IDLE: state <= S_WAIT;
        S_WAIT: if (full_sel) state <= S_READ;
        S_READ: begin
          if (last) begin
            rd_bank <= !rd_bank;
            state   <= other_full ? S_READ : S_WAIT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Address walk: +ROWS per step, on row wrap jump to the next column start.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      k    <= '0;
      addr <= '0;
      col  <= '0;
      row  <= '0;
    end else if (adv) begin
      if (last) begin
        k    <= '0;
        addr <= '0;
        col  <= '0;
        row  <= '0;
      end else begin
        k <= k + 1'b1;
        if (INTERLEAVE != 0) begin
          if (row == RW'(D - 1)) begin
            row  <= '0;
            col  <= col + 1'b1;
            addr <= col + 1'b1;
          end else begin
            row  <= row + 1'b1;
            addr <= addr + ADDR_W'(ROWS);
          end
        end else begin
          addr <= k + 1'b1;
        end
      end
    end
  end

  // Output stage: RAM data lands one cycle after rden, valid tracks it.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      valid_r <= 1'b0;
      q_sel   <= 1'b0;
    end else begin
      if (!valid_r || bus.ready_in) valid_r <= adv;
      if (adv) q_sel <= rd_bank;
    end
  end

endmodule

// File: tb/tb_ppbuf_read_ctrl.sv
// Bench for ppbuf_read_ctrl: behavioural RAMs, an interleaved and a linear
// instance, a read/beat scoreboard and a directed test sequence.
module tb_ppbuf_read_ctrl;

  localparam int N = 192;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  logic       wr_done_A = 1'b0, wr_done_B = 1'b0;
  logic       rd_done_A, rd_done_B, err_ovf;
  logic [1:0] state_dbg;
  logic       l_wr_done_A = 1'b0, l_wr_done_B = 1'b0;
  logic       l_rd_done_A, l_rd_done_B, l_err_ovf;
  logic [1:0] l_state_dbg;

  ppbuf_read_ctrl_if #(.ADDR_W(8)) bus ();
  ppbuf_read_ctrl_if #(.ADDR_W(8)) lbus ();

  ppbuf_read_ctrl #(.NCBPS(N), .D(16), .ADDR_W(8), .INTERLEAVE(1)) dut (
    .clk(clk), .resetN(resetN), .wr_done_A(wr_done_A), .wr_done_B(wr_done_B),
    .rd_done_A(rd_done_A), .rd_done_B(rd_done_B), .err_ovf(err_ovf),
    .state_dbg(state_dbg), .bus(bus)
  );

  ppbuf_read_ctrl #(.NCBPS(N), .D(16), .ADDR_W(8), .INTERLEAVE(0)) dut_lin (
    .clk(clk), .resetN(resetN), .wr_done_A(l_wr_done_A), .wr_done_B(l_wr_done_B),
    .rd_done_A(l_rd_done_A), .rd_done_B(l_rd_done_B), .err_ovf(l_err_ovf),
    .state_dbg(l_state_dbg), .bus(lbus)
  );

  // ---------------- RAM models (1-cycle latency, hold while rden low)
  logic mem_a [N];
  logic mem_b [N];
  logic mem_l [N];

  always @(posedge clk) begin
    if (bus.rden_A)  bus.q_A  <= mem_a[bus.rdaddress];
    if (bus.rden_B)  bus.q_B  <= mem_b[bus.rdaddress];
    if (lbus.rden_A) lbus.q_A <= mem_l[lbus.rdaddress];
  end
  assign lbus.q_B = 1'b0;

  // ---------------- scoreboard
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [9:0] rd_q[$];     // {bank, last, addr}
  logic [0:0] exp_q[$];    // expected q_out beats, interleaved instance
  logic [0:0] lin_q[$];    // expected q_out beats, linear instance
  int beats = 0;
  int rd_issued = 0;
  int lin_k = 0;
  int lin_beats = 0;
  logic        stall_prev = 1'b0;
  logic [8:0]  stall_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] il_addr(input int k);
    return 8'((k % 16) * 12 + k / 16);
  endfunction

  task automatic push_block(input logic bank);
    logic [7:0] a;
    for (int k = 0; k < N; k++) begin
      a = il_addr(k);
      rd_q.push_back({bank, (k == N - 1), a});
      exp_q.push_back(bank ? mem_b[a] : mem_a[a]);
    end
  endtask

  task automatic fill(input int which, input bit pattern);
    logic v;
    for (int i = 0; i < N; i++) begin
      v = pattern ? i[0] : 1'($urandom_range(0, 1));
      case (which)
        0:       mem_a[i] = v;
        1:       mem_b[i] = v;
        default: mem_l[i] = v;
      endcase
    end
  endtask

  // Monitor: every read issue and every accepted beat is checked at negedge.
  always @(negedge clk) begin
    logic [9:0] e;
    if (resetN) begin
      if (bus.rden_A || bus.rden_B) begin
        rd_issued++;
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          e = rd_q.pop_front();
          check("rd_issue", {bus.rden_A, bus.rden_B, rd_done_A, rd_done_B, bus.rdaddress},
                {!e[9], e[9], e[8] && !e[9], e[8] && e[9], e[7:0]});
        end
      end else begin
        check("rd_done_idle", {rd_done_A, rd_done_B}, 0);
      end
      if (stall_prev) check("stall_hold", {bus.q_out, bus.rdaddress}, stall_val);
      stall_prev = bus.valid_out && !bus.ready_in;
      stall_val  = {bus.q_out, bus.rdaddress};
      if (stall_prev) check("stall_rden", {bus.rden_A, bus.rden_B}, 0);
      if (bus.valid_out && bus.ready_in) begin
        beats++;
        if (exp_q.size() == 0) check("beat_unexpected", 1, 0);
        else check("q_out", bus.q_out, exp_q.pop_front());
      end
      if (lbus.rden_A || lbus.rden_B) begin
        check("lin_addr", {lbus.rden_B, lbus.rdaddress, l_rd_done_A},
              {1'b0, lin_k[7:0], (lin_k == N - 1)});
        lin_k++;
      end
      if (lbus.valid_out && lbus.ready_in) begin
        lin_beats++;
        if (lin_q.size() == 0) check("lin_beat_unexpected", 1, 0);
        else check("lin_q_out", lbus.q_out, lin_q.pop_front());
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver tasks (inputs change 1 time unit after posedge)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    case (which)
      0:       wr_done_A = 1'b1;
      1:       wr_done_B = 1'b1;
      default: l_wr_done_A = 1'b1;
    endcase
    step();
    wr_done_A = 1'b0;
    wr_done_B = 1'b0;
    l_wr_done_A = 1'b0;
  endtask

  // Pulse a bank while the controller waits and check the 2-cycle latency.
  task automatic pulse_lat(input int which, input string tag);
    pulse(which);
    check({tag, "_lat0"}, bus.valid_out, 0);
    step();
    check({tag, "_lat1"}, bus.valid_out, 0);
    step();
    check({tag, "_lat2"}, bus.valid_out, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while ((rd_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      step();
      n++;
    end
    check({tag, "_drained"}, (rd_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  // ---------------- directed sequence
  initial begin
    int n;
    int gaps;
    int b0;
    bus.ready_in  = 1'b0;
    lbus.ready_in = 1'b0;

    // reset
    resetN = 1'b0;
    step();
    step();
    check("reset_outputs", {rd_done_A, rd_done_B, bus.rden_A, bus.rden_B, bus.rdaddress,
                            bus.valid_out, bus.q_out, err_ovf, state_dbg}, 0);
    resetN = 1'b1;
    step();
    step();
    step();
    check("idle_to_wait", state_dbg, ST_WAIT);

    // basic drain of bank A, bit[i] = i[0]
    fill(0, 1'b1);
    push_block(1'b0);
    bus.ready_in = 1'b1;
    pulse_lat(0, "basic");
    wait_drain("basic");
    step();
    step();
    check("basic_valid_low", bus.valid_out, 0);
    check("basic_state_wait", state_dbg, ST_WAIT);

    // starvation: bank B arrives later, output resumes after 2 cycles
    repeat (10) step();
    fill(1, 1'b0);
    push_block(1'b1);
    pulse_lat(1, "starve");
    wait_drain("starve");

    // ping-pong back-to-back: A then B with no bubble
    fill(0, 1'b0);
    fill(1, 1'b0);
    push_block(1'b0);
    push_block(1'b1);
    pulse(0);
    repeat (5) step();
    pulse(1);
    n = 0;
    while (!rd_done_A && n < 400) begin
      step();
      n++;
    end
    check("pp_rd_done_A_seen", rd_done_A, 1);
    n = 0;
    gaps = 0;
    do begin
      step();
      n++;
      if (!bus.valid_out) gaps++;
    end while (!rd_done_B && n < 400);
    check("pp_rd_done_spacing", n, N);
    check("pp_valid_gaps", gaps, 0);
    wait_drain("pingpong");

    // backpressure 1,0,0,1 on bank A
    fill(0, 1'b0);
    push_block(1'b0);
    b0 = beats;
    pulse(0);
    n = 0;
    while ((rd_q.size() != 0 || exp_q.size() != 0) && n < 2000) begin
      bus.ready_in = (n % 4 == 0) || (n % 4 == 3);
      step();
      n++;
    end
    bus.ready_in = 1'b1;
    wait_drain("backpressure");
    check("bp_beat_count", beats - b0, N);

    // same-cycle refill of A with its final read: no overflow
    fill(1, 1'b0);
    fill(0, 1'b0);
    push_block(1'b1);
    push_block(1'b0);
    pulse(1);
    pulse(0);
    n = 0;
    while (!(bus.rden_A && bus.rdaddress == 8'd191) && n < 800) begin
      step();
      n++;
    end
    check("sc_last_read_seen", {bus.rden_A, bus.rdaddress}, {1'b1, 8'd191});
    wr_done_A = 1'b1;
    step();
    wr_done_A = 1'b0;
    check("sc_no_ovf", err_ovf, 0);
    fill(1, 1'b0);
    push_block(1'b1);
    push_block(1'b0);   // refilled A (same contents) drains after B
    pulse(1);
    wait_drain("samecycle");
    check("sc_no_ovf_after", err_ovf, 0);

    // overflow: second wr_done_B while B still full
    fill(1, 1'b0);
    push_block(1'b1);
    pulse(1);
    repeat (20) step();
    pulse(1);
    check("ovf_set", err_ovf, 1);
    wait_drain("overflow");
    repeat (5) step();
    check("ovf_sticky", err_ovf, 1);

    // reset in the middle of a block of A, at k = 77
    fill(0, 1'b0);
    push_block(1'b0);
    b0 = rd_issued;
    pulse(0);
    n = 0;
    while (rd_issued < b0 + 77 && n < 400) begin
      step();
      n++;
    end
    check("mid_k77_reached", rd_issued - b0, 77);
    resetN = 1'b0;
    #1;
    check("mid_reset_outputs", {rd_done_A, rd_done_B, bus.rden_A, bus.rden_B, bus.rdaddress,
                                bus.valid_out, bus.q_out, err_ovf, state_dbg}, 0);
    rd_q.delete();
    exp_q.delete();
    step();
    resetN = 1'b1;
    step();
    step();
    step();

    // linear instance: addresses 0..191 in order
    fill(2, 1'b0);
    for (int k = 0; k < N; k++) lin_q.push_back(mem_l[k]);
    lin_k = 0;
    lin_beats = 0;
    lbus.ready_in = 1'b1;
    pulse(2);
    n = 0;
    while (lin_q.size() != 0 && n < 1000) begin
      step();
      n++;
    end
    repeat (3) step();
    check("lin_read_count", lin_k, N);
    check("lin_beat_count", lin_beats, N);
    check("post_reset_no_release", {rd_done_A, bus.valid_out}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/ppbuf_read_ctrl.md
Name: ppbuf_read_ctrl

Overview:
- Read-side controller for the ping-pong interleaver buffer (banks A/B, 192 one-bit entries each).
- The write side fills a bank in natural order. This block drains the full bank in block-interleaved address order and streams the bits downstream with a valid/ready handshake.
- It pulses a release to the write side when a bank has been fully read.
- It sits between the ping-pong RAMs and the modulator mapper.

Parameters:
- NCBPS, 192, coded bits per block (bank depth).
- D, 16, interleaver column count; NCBPS/D = 12 rows.
- ADDR_W, 8, bank address width.
- INTERLEAVE, 1, 1 = permuted read order, 0 = linear read order (bypass/debug).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- wr_done_A  in  1  one-cycle pulse: writer finished filling bank A.
- wr_done_B  in  1  one-cycle pulse: writer finished filling bank B.
- rd_done_A  out  1  one-cycle pulse: bank A fully read, may be rewritten.
- rd_done_B  out  1  one-cycle pulse: bank B fully read, may be rewritten.
- rden_A  out  1  bank A read enable.
- rden_B  out  1  bank B read enable.
- rdaddress  out  ADDR_W  read address, shared by both banks.
- q_A  in  1  bank A read data; 1-cycle latency; held while rden_A low.
- q_B  in  1  bank B read data; same rules as q_A.
- valid_out  out  1  q_out valid.
- ready_in  in  1  downstream accepts q_out.
- q_out  out  1  interleaved output bit.
- err_ovf  out  1  sticky: wr_done received for a bank still marked full.

Behaviour:
- Reset values: all outputs 0, state IDLE, full_A = full_B = 0, rd_bank = A, k = 0, err_ovf = 0.
- Full flags: wr_done_X sets full_X. The cycle issuing the last read of bank X clears full_X and pulses rd_done_X in that same cycle. If set and clear land on the same cycle, set wins.
- Overflow: wr_done_X while full_X = 1 and not being cleared that cycle sets err_ovf. err_ovf is cleared only by reset.
- Advance condition: adv = (state == READ) && (!valid_out || ready_in).
- rden_X = adv && (rd_bank == X). Only one bank's rden is high in any cycle.
- Address, with k = 0..NCBPS-1, row = k mod D, col = k / D:
  - INTERLEAVE = 1: rdaddress = row*(NCBPS/D) + col. Generated incrementally (add 12 per step; on row wrap, load col+1); no multiplier.
  - INTERLEAVE = 0: rdaddress = k.
- Example sequence (INTERLEAVE = 1): 0, 12, 24, ..., 180, 1, 13, ..., 191. k = 191 maps to address 191.
- State machine:
  - IDLE: go to WAIT after 1 cycle.
  - WAIT: when full[rd_bank] = 1, go to READ.
  - READ: on adv with k == NCBPS-1: k = 0, toggle rd_bank, pulse rd_done. Then go to READ if the other bank's full flag (including a same-cycle wr_done) is set, else WAIT.
  - Back-to-back blocks have zero bubble cycles.
- Output pipeline:
  - valid_out is registered: set to adv on any cycle where (!valid_out || ready_in); otherwise held.
  - q_sel is registered as rd_bank on adv. q_out = q_sel ? q_B : q_A.
  - During a stall (valid_out && !ready_in), rden is low, so RAM data and q_out hold stable.
- Latency: first valid_out is 2 cycles after the cycle full[rd_bank] is seen in WAIT (WAIT→READ, read issue, data valid).
- Throughput: 1 bit/cycle while ready_in = 1.
- Reset mid-block: immediate return to reset values. The partially read bank is not released. The writer restarts by the same reset.

Test Plan:
- Basic drain: bank A preloaded with bit[i] = i[0], wr_done_A pulse, ready_in = 1 → rdaddress sequence 0, 12, ..., 180, 1, ..., 191; 192 valid beats; q_out = addr[0]; one rd_done_A pulse coincident with the read of address 191.
- Ping-pong back-to-back: wr_done_B arrives while A is draining → read of B address 0 issues the cycle after A address 191; valid_out never drops across the boundary; rd_done_B pulses 192 cycles after rd_done_A.
- Backpressure: ready_in toggles 1,0,0,1 repeatedly → q_out and rdaddress hold during stalls; no bit lost or duplicated; exactly 192 accepted beats, matching the permuted sequence.
- Starvation: only bank A written → after rd_done_A, state WAIT, valid_out falls to 0 after the last beat accepted; wr_done_B 10 cycles later resumes output 2 cycles after WAIT sees full_B.
- Overflow: second wr_done_A before A is drained → err_ovf = 1 and stays 1; a same-cycle wr_done_A with the final A read sets full_A without setting err_ovf.
- Reset mid-block plus linear mode: resetN low at k = 77 → all outputs 0 asynchronously. With INTERLEAVE = 0, addresses after restart run 0..191 sequentially.
